// File: rtl/neuron_accumulator.sv
// Sums NP beats of NC signed products per sample (plus optional per-lane bias) and
// hands the finished vector downstream on valid/ready. Optional bias: ACCUM_BIAS_EN.
module neuron_accumulator #(
    parameter int NP = 4,
    parameter int NC = 4,
    parameter int WF = 4,
    localparam int WA = $clog2(NP) + 1 + WF
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid_AM_Prod0,
    output logic             oReady_AM_Prod0,
    input  logic [NC*WF-1:0] iData_AM_Prod0,
`ifdef ACCUM_BIAS_EN
    input  logic [NC*WF-1:0] iData_AM_Bias0,
`endif
    output logic             oValid_BM_Accum0,
    input  logic             iReady_BM_Accum0,
    output logic [NC*WA-1:0] oData_BM_Accum0
);

    localparam int CW = $clog2(NP);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [NC*WA-1:0] sum;
    logic [NC*WA-1:0] next_sum;
    logic [NC*WF-1:0] bias;
    logic             last_beat;
    logic             beat;
    logic             drain;

`ifdef ACCUM_BIAS_EN
    assign bias = iData_AM_Bias0;
`else
    assign bias = '0;
`endif

    function automatic logic [WA-1:0] sext(input logic [WF-1:0] v);
        return {{(WA-WF){v[WF-1]}}, v};
    endfunction

    // Only the final beat can stall: it needs the output register to be free or draining.
    assign last_beat       = (cnt == CW'(NP-1));
    assign oReady_AM_Prod0 = !(last_beat && oValid_BM_Accum0 && !iReady_BM_Accum0);
    assign beat            = iValid_AM_Prod0 && oReady_AM_Prod0;
    assign drain           = oValid_BM_Accum0 && iReady_BM_Accum0;

    // Beat 0 restarts from the bias instead of the stale sum.
    always_comb begin
        next_sum = '0;
        for (int i = 0; i < NC; i++) begin
            next_sum[i*WA +: WA] = ((cnt == '0) ? sext(bias[i*WF +: WF]) : sum[i*WA +: WA])
                                   + sext(iData_AM_Prod0[i*WF +: WF]);
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt              <= '0;
            sum              <= '0;
            state            <= ACCUM;
            oValid_BM_Accum0 <= 1'b0;
            oData_BM_Accum0  <= '0;
        end else begin
            if (beat) begin
                sum <= next_sum;
                cnt <= last_beat ? '0 : cnt + CW'(1);
            end
            case (state)
                ACCUM: begin
                    if (beat && last_beat) begin
                        state            <= HOLD;
                        oValid_BM_Accum0 <= 1'b1;
                        oData_BM_Accum0  <= next_sum;
                    end
                end
                HOLD: begin
                    // An accepted final beat here implies the old result is draining this cycle.
                    if (beat && last_beat) begin
                        oData_BM_Accum0 <= next_sum;
                    end else if (drain) begin
                        state            <= ACCUM;
                        oValid_BM_Accum0 <= 1'b0;
                    end
                end
                default: begin
                    state            <= ACCUM;
                    oValid_BM_Accum0 <= 1'b0;
                end
            endcase
        end
    end

endmodule
